nibble_serial_adder: RTL and testbench

Multi-cycle WIDTH-bit adder/subtractor built around a single instance of the existing 4-bit ripple adder. Operands are processed one nibble per cycle, least-significant nibble first, and the carry is registered between cycles. It sits between the register file operand bus and the result/flag writeback. It is the datapath arithmetic stage for operand widths wider than 4 bits, and it uses a start/busy/done handshake.

---
 rtl/nibble_serial_adder_pkg.sv | 13 +
 rtl/ripple_adder_4bit.sv | 30 +++
 rtl/nibble_serial_adder.sv | 136 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared types and constants for the nibble-serial adder
//
// Purpose: state encoding and nibble size shared by the serial adder files.
package nibble_serial_adder_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/ripple_adder_4bit.sv
// rtl/ripple_adder_4bit.sv - 4-bit ripple-carry adder
//
// Purpose: purely combinational 4-bit adder with carry in/out.
// Ports:
//   a, b  in  4  addends
//   cin   in  1  carry in
//   sum   out 4  a + b + cin (low 4 bits)
//   cout  out 1  carry out of bit 3
module ripple_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle WIDTH-bit add/sub, one nibble per cycle
//
// Purpose: adds or subtracts two WIDTH-bit operands through a single 4-bit
// ripple adder, least-significant nibble first, carry registered between
// cycles. Flags are updated only when the last nibble completes.
// Ports:
//   clk        in  1      clock, rising edge
//   rst_n      in  1      synchronous active-low reset
//   start      in  1      begin an operation (sampled in IDLE only)
//   sub        in  1      0: a + b + carry_in, 1: a - b
//   a, b       in  WIDTH  operands, captured on accepted start
//   carry_in   in  1      initial carry for add
//   busy       out 1      operation in progress
//   done       out 1      one-cycle completion pulse
//   sum        out WIDTH  result (valid when busy = 0)
//   carry_out  out 1      final carry (sub: 1 = no borrow)
//   overflow   out 1      signed overflow
//   zero       out 1      result is zero
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int N     = WIDTH / NIBBLE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   idx;
  logic               carry_q;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;

  logic [NIBBLE-1:0]  nib_a;
  logic [NIBBLE-1:0]  nib_b;
  logic [NIBBLE-1:0]  nib_sum;
  logic               nib_cout;
  logic [WIDTH-1:0]   sum_next;
  logic               last;

  // Nibble mux: select the current nibble of each captured operand.
  assign nib_a = op_a[NIBBLE*int'(idx) +: NIBBLE];
  assign nib_b = op_b[NIBBLE*int'(idx) +: NIBBLE];
  assign last  = (idx == LAST_IDX);

  ripple_adder_4bit u_adder (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Nibble demux: the full result as it will look after this edge, so the
  // flags can be computed from the final value in the completing cycle.
  always_comb begin
    sum_next = sum;
    sum_next[NIBBLE*int'(idx) +: NIBBLE] = nib_sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      carry_q   <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1, so invert b here and force carry.
            op_a    <= a;
            op_b    <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : carry_in;
            idx     <= '0;
          end
        end
        RUN: begin
          sum     <= sum_next;
          carry_q <= nib_cout;
          idx     <= idx + IDX_W'(1);
          if (last) begin
            done      <= 1'b1;
            carry_out <= nib_cout;
            zero      <= (sum_next == '0);
            overflow  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                         (sum_next[WIDTH-1] != op_a[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        carry_out;
  logic        overflow;
  logic        zero;

  int compared;
  int mismatched;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Issue one operation and return the number of edges from the start edge to done.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tcin, input logic tsub, output int lat);
    a = ta; b = tb_v; carry_in = tcin; sub = tsub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat;
  int done_cnt;
  int done_cyc [2];
  logic [15:0] done_sum [2];

  initial begin
    compared = 0;
    mismatched = 0;
    rst_n = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; carry_in = 1'b0;

    // Reset with random inputs applied
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); carry_in = 1'($urandom);
    start = 1'($urandom);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'h0);
    check("rst_cout", 32'(carry_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 0x00FF + 0x0001
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
    check("lat_add1", 32'(lat), 32'd4);
    check("busy_at_done", 32'(busy), 32'd0);
    check("sum_add1", 32'(sum), 32'h0100);
    check("cout_add1", 32'(carry_out), 32'd0);
    check("ovf_add1", 32'(overflow), 32'd0);
    check("zero_add1", 32'(zero), 32'd0);
    @(posedge clk); #1;
    check("done_falls", 32'(done), 32'd0);
    check("flags_hold", 32'(sum), 32'h0100);

    // 0xFFFF + 0x0001 wraps to zero
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    check("lat_add2", 32'(lat), 32'd4);
    check("sum_add2", 32'(sum), 32'h0000);
    check("cout_add2", 32'(carry_out), 32'd1);
    check("zero_add2", 32'(zero), 32'd1);
    check("ovf_add2", 32'(overflow), 32'd0);

    // 0x7FFF + 0 + carry_in -> signed overflow
    run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, lat);
    check("sum_add3", 32'(sum), 32'h8000);
    check("ovf_add3", 32'(overflow), 32'd1);
    check("cout_add3", 32'(carry_out), 32'd0);
    check("zero_add3", 32'(zero), 32'd0);

    // 5 - 7 = -2 with borrow; carry_in must be ignored
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat);
    check("lat_sub", 32'(lat), 32'd4);
    check("sum_sub", 32'(sum), 32'hFFFE);
    check("cout_sub", 32'(carry_out), 32'd0);
    check("ovf_sub", 32'(overflow), 32'd0);
    check("zero_sub", 32'(zero), 32'd0);
    @(posedge clk); #1;

    // Start held high: operands change mid-RUN, back-to-back operation
    a = 16'h0010; b = 16'h0020; sub = 1'b0; carry_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'h1111; b = 16'h2222;
    done_cnt = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        if (done_cnt < 2) begin
          done_cyc[done_cnt] = cyc;
          done_sum[done_cnt] = sum;
        end
        done_cnt++;
      end
      if (cyc == 4) check("held_busy_at_done", 32'(busy), 32'd0);
      if (cyc == 5) begin
        check("held_restart_busy", 32'(busy), 32'd1);
        a = 16'hAAAA; b = 16'h5555;
        start = 1'b0;
      end
    end
    check("held_done_count", 32'(done_cnt), 32'd2);
    if (done_cnt >= 2) begin
      check("held_cyc0", 32'(done_cyc[0]), 32'd4);
      check("held_sum0", 32'(done_sum[0]), 32'h0030);
      check("held_cyc1", 32'(done_cyc[1]), 32'd9);
      check("held_sum1", 32'(done_sum[1]), 32'h3333);
    end

    // Reset in the middle of an operation
    a = 16'h1234; b = 16'h1111; sub = 1'b0; carry_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'h0);
    check("abort_flags", 32'({carry_out, overflow, zero}), 32'd0);
    done_cnt = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
    check("lat_after_abort", 32'(lat), 32'd4);
    check("sum_after_abort", 32'(sum), 32'h2345);
    check("flags_after_abort", 32'({carry_out, overflow, zero}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
